// File: rtl/vc_buffer_n.sv
// NVC circular FIFOs behind one steered write port and one arbitrated (strict or round-robin) read port.
// Read data is registered: a grant at edge N shows on data_out after N. Writes to a full channel are dropped and flagged.
module vc_buffer_n #(
  parameter int BW    = 6,
  parameter int NVC   = 2,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1,
  parameter int SW    = (NVC > 1) ? $clog2(NVC) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [SW-1:0]     vc_sel_in,
  input  logic [BW-1:0]     data_in,
  input  logic              rd_en,
  input  logic              arb_mode,
  input  logic              err_clr,
  input  logic [NVC*CW-1:0] umbral_bajo,
  input  logic [NVC*CW-1:0] umbral_alto,
  output logic [BW-1:0]     data_out,
  output logic              valid_out,
  output logic [SW-1:0]     vc_out,
  output logic [NVC-1:0]    fifo_full,
  output logic [NVC-1:0]    fifo_empty,
  output logic [NVC-1:0]    fifo_almost_full,
  output logic [NVC-1:0]    fifo_almost_empty,
  output logic [NVC*CW-1:0] fifo_count,
  output logic [NVC-1:0]    error_output
);

  logic [BW-1:0]  mem_q    [NVC][DEPTH];
  logic [AW-1:0]  wr_ptr_q [NVC];
  logic [AW-1:0]  wr_ptr_d [NVC];
  logic [AW-1:0]  rd_ptr_q [NVC];
  logic [AW-1:0]  rd_ptr_d [NVC];
  logic [CW-1:0]  cnt_q    [NVC];
  logic [CW-1:0]  cnt_d    [NVC];
  logic [NVC-1:0] err_q, err_d;
  logic [NVC-1:0] full, wr_acc, rd_gnt, err_set;
  logic [SW-1:0]  rr_q, rr_d;
  logic [SW-1:0]  gnt_idx, rr_idx;
  logic           gnt_vld, sel_ok;
  logic [BW-1:0]  dout_q, dout_d;
  logic [SW-1:0]  vc_q, vc_d;
  logic           vld_q, vld_d;

  // Flags are live against the threshold inputs; nothing here is latched.
  always_comb begin
    full              = '0;
    fifo_full         = '0;
    fifo_empty        = '0;
    fifo_almost_full  = '0;
    fifo_almost_empty = '0;
    fifo_count        = '0;
    for (int i = 0; i < NVC; i++) begin
      full[i]                = (cnt_q[i] == CW'(DEPTH));
      fifo_full[i]           = full[i];
      fifo_empty[i]          = (cnt_q[i] == '0);
      fifo_almost_full[i]    = (cnt_q[i] >= umbral_alto[i*CW +: CW]);
      fifo_almost_empty[i]   = (cnt_q[i] <= umbral_bajo[i*CW +: CW]);
      fifo_count[i*CW +: CW] = cnt_q[i];
    end
  end

  // Descending scan so the last hit (lowest index / smallest rr offset) wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    if (rd_en) begin
      if (!arb_mode) begin
        for (int i = NVC - 1; i >= 0; i--) begin
          if (cnt_q[i] != '0) begin
            gnt_vld = 1'b1;
            gnt_idx = SW'(i);
          end
        end
      end else begin
        for (int k = NVC - 1; k >= 0; k--) begin
          rr_idx = SW'((int'(rr_q) + k) % NVC);
          if (cnt_q[rr_idx] != '0) begin
            gnt_vld = 1'b1;
            gnt_idx = rr_idx;
          end
        end
      end
    end
  end

  always_comb begin
    sel_ok  = (32'(vc_sel_in) < NVC);
    wr_acc  = '0;
    rd_gnt  = '0;
    err_set = '0;
    err_d   = '0;
    for (int i = 0; i < NVC; i++) begin
      wr_acc[i]   = valid_in && sel_ok && (vc_sel_in == SW'(i)) && !full[i];
      rd_gnt[i]   = gnt_vld && (gnt_idx == SW'(i));
      err_set[i]  = valid_in && ((sel_ok && (vc_sel_in == SW'(i)) && full[i]) ||
                                 (!sel_ok && (i == NVC - 1)));
      wr_ptr_d[i] = wr_acc[i] ? wr_ptr_q[i] + AW'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = rd_gnt[i] ? rd_ptr_q[i] + AW'(1) : rd_ptr_q[i];
      case ({wr_acc[i], rd_gnt[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      // A new error in the clear cycle must survive the clear.
      err_d[i] = err_set[i] | (err_q[i] & ~err_clr);
    end
    rr_d = rr_q;
    if (arb_mode && gnt_vld) rr_d = SW'((int'(gnt_idx) + 1) % NVC);
    vld_d  = gnt_vld;
    dout_d = dout_q;
    vc_d   = vc_q;
    if (gnt_vld) begin
      dout_d = mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
      vc_d   = gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NVC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      err_q  <= '0;
      rr_q   <= '0;
      dout_q <= '0;
      vc_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rr_q     <= rr_d;
      dout_q   <= dout_d;
      vc_q     <= vc_d;
      vld_q    <= vld_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NVC; i++) begin
      if (wr_acc[i]) mem_q[i][wr_ptr_q[i]] <= data_in;
    end
  end

  assign data_out     = dout_q;
  assign valid_out    = vld_q;
  assign vc_out       = vc_q;
  assign error_output = err_q;

endmodule

// File: tb/tb_vc_buffer_n.sv
// Directed bench for vc_buffer_n at default parameters (BW=6, NVC=2, DEPTH=16).
module tb_vc_buffer_n;
  localparam int BW = 6, NVC = 2, DEPTH = 16, CW = 5, SW = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [SW-1:0]     vc_sel_in;
  logic [BW-1:0]     data_in;
  logic              rd_en;
  logic              arb_mode;
  logic              err_clr;
  logic [NVC*CW-1:0] umbral_bajo;
  logic [NVC*CW-1:0] umbral_alto;
  logic [BW-1:0]     data_out;
  logic              valid_out;
  logic [SW-1:0]     vc_out;
  logic [NVC-1:0]    fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic [NVC*CW-1:0] fifo_count;
  logic [NVC-1:0]    error_output;

  int n_chk  = 0;
  int n_pass = 0;

  vc_buffer_n #(.BW(BW), .NVC(NVC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .vc_sel_in(vc_sel_in),
    .data_in(data_in), .rd_en(rd_en), .arb_mode(arb_mode), .err_clr(err_clr),
    .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto), .data_out(data_out),
    .valid_out(valid_out), .vc_out(vc_out), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_almost_full(fifo_almost_full),
    .fifo_almost_empty(fifo_almost_empty), .fifo_count(fifo_count),
    .error_output(error_output)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [SW-1:0] vc, input logic [BW-1:0] d);
    valid_in  = 1'b1;
    vc_sel_in = vc;
    data_in   = d;
    tick();
    valid_in  = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt(input int ch);
    return fifo_count[ch*CW +: CW];
  endfunction

  initial begin
    reset = 1'b1; valid_in = 1'b0; vc_sel_in = '0; data_in = '0;
    rd_en = 1'b0; arb_mode = 1'b0; err_clr = 1'b0;
    umbral_alto = {5'd12, 5'd16};
    umbral_bajo = {5'd3, 5'd0};
    tick(); tick();

    chk("rst_empty",  fifo_empty, 2'b11);
    chk("rst_full",   fifo_full, 2'b00);
    chk("rst_count",  fifo_count, 0);
    chk("rst_valid",  valid_out, 0);
    chk("rst_data",   data_out, 0);
    chk("rst_err",    error_output, 0);
    chk("rst_aempty", fifo_almost_empty, 2'b11);
    chk("rst_afull",  fifo_almost_full, 2'b00);
    reset = 1'b0;
    tick();

    // Fill VC0 to full, then overflow.
    for (int i = 0; i < 16; i++) wr(0, BW'(i + 1));
    chk("vc0_full",   fifo_full[0], 1);
    chk("vc0_cnt16",  cnt(0), 16);
    chk("vc0_afull",  fifo_almost_full[0], 1);
    wr(0, 6'h3F);
    chk("ovf_err",    error_output, 2'b01);
    chk("ovf_cnt",    cnt(0), 16);

    err_clr = 1'b1;
    tick();
    chk("clr_err",    error_output, 2'b00);
    wr(0, 6'h3E);
    chk("clr_vs_ovf", error_output, 2'b01);
    tick();
    err_clr = 1'b0;
    chk("clr_again",  error_output, 2'b00);

    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_vld",  valid_out, 1);
      chk("drain_data", data_out, i + 1);
      chk("drain_vc",   vc_out, 0);
    end
    rd_en = 1'b0;
    tick();
    chk("drain_idle",  valid_out, 0);
    chk("drain_hold",  data_out, 6'h10);
    chk("drain_empty", fifo_empty[0], 1);

    // VC1 watermarks: low 3, high 12.
    for (int i = 0; i < 12; i++) begin
      wr(1, BW'(6'h20 + i));
      if (i == 2)  chk("wm_ae_at3",  fifo_almost_empty[1], 1);
      if (i == 3)  chk("wm_ae_at4",  fifo_almost_empty[1], 0);
      if (i == 10) chk("wm_af_at11", fifo_almost_full[1], 0);
      if (i == 11) chk("wm_af_at12", fifo_almost_full[1], 1);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("wm_data", data_out, 6'h20 + i);
      chk("wm_vc",   vc_out, 1);
      if (i == 0) chk("wm_af_back11", fifo_almost_full[1], 0);
      if (i == 7) chk("wm_ae_back4",  fifo_almost_empty[1], 0);
      if (i == 8) chk("wm_ae_back3",  fifo_almost_empty[1], 1);
    end
    rd_en = 1'b0;
    tick();
    chk("wm_empty", fifo_empty, 2'b11);

    // Strict priority: 0,0,0,0,1,1,1,1.
    for (int i = 0; i < 4; i++) wr(0, BW'(6'h01 + i));
    for (int i = 0; i < 4; i++) wr(1, BW'(6'h11 + i));
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("sp_vc",   vc_out, (i < 4) ? 0 : 1);
      chk("sp_data", data_out, (i < 4) ? 6'h01 + i : 6'h11 + i - 4);
    end
    rd_en = 1'b0;

    // Round-robin: 0,1,0,1,...
    for (int i = 0; i < 4; i++) wr(0, BW'(6'h01 + i));
    for (int i = 0; i < 4; i++) wr(1, BW'(6'h11 + i));
    arb_mode = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_vc",   vc_out, i % 2);
      chk("rr_data", data_out, (i % 2 == 0) ? 6'h01 + i / 2 : 6'h11 + i / 2);
    end
    rd_en = 1'b0;
    arb_mode = 1'b0;
    tick();
    chk("rr_empty", fifo_empty, 2'b11);

    // Steady state write+read at count 5 on VC0, pointers wrap.
    for (int i = 0; i < 5; i++) wr(0, BW'(i));
    chk("ss_cnt_init", cnt(0), 5);
    valid_in = 1'b1; vc_sel_in = 0; rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      data_in = BW'(5 + k);
      tick();
      chk("ss_data", data_out, k);
      chk("ss_cnt",  cnt(0), 5);
      chk("ss_vld",  valid_out, 1);
    end

    // Asynchronous reset mid-cycle with traffic still driven.
    #2 reset = 1'b1;
    #1;
    chk("arst_vld",   valid_out, 0);
    chk("arst_cnt",   fifo_count, 0);
    chk("arst_empty", fifo_empty, 2'b11);
    chk("arst_data",  data_out, 0);
    chk("arst_vc",    vc_out, 0);
    chk("arst_err",   error_output, 0);
    valid_in = 1'b0; rd_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_vld", valid_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
